// File: rtl/ddr5_phy_wrdata_align.sv
`default_nettype none
// ============================================================================
//  Module   : ddr5_phy_wrdata_align
//  Purpose  : Delays DFI write data by a programmable write latency and tracks
//             burst framing, flagging truncated bursts and latency changes.
//  Revision : 1.0  initial release
// ============================================================================
module ddr5_phy_wrdata_align #(
  parameter int pDRAM_SIZE = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      dfi_wrdata_en_i,
  input  logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_i,
  input  logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_i,
  input  logic [3:0]                wrlat_i,
  input  logic [1:0]                burstlength_i,
  output logic                      wr_en_o,
  output logic [2*pDRAM_SIZE-1:0]   wr_data_o,
  output logic [pDRAM_SIZE/4-1:0]   wr_datamask_o,
  output logic                      busy_o,
  output logic                      burst_err_o,
  output logic                      lat_err_o
);

  localparam int DW    = 2*pDRAM_SIZE;
  localparam int MW    = pDRAM_SIZE/4;
  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic [4:0]       n_q, n_d;
  logic [4:0]       beat_q, beat_d;
  logic             lat_mis_q, lat_mis_d;
  logic [DEPTH-1:1] vld_q, vld_d;
  logic [DW-1:0]    data_q [1:DEPTH-1];
  logic [DW-1:0]    data_d [1:DEPTH-1];
  logic [MW-1:0]    mask_q [1:DEPTH-1];
  logic [MW-1:0]    mask_d [1:DEPTH-1];
  logic             wr_en_q, wr_en_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [MW-1:0]    wr_mask_q, wr_mask_d;

  logic             gated_en;
  logic             is_idle;
  logic             lat_cond;
  logic [3:0]       lat_eff;
  logic [4:0]       n_cfg;
  logic [4:0]       n_eff;
  logic [DEPTH-1:0] tap_vld;
  logic [DW-1:0]    tap_data [0:DEPTH-1];
  logic [MW-1:0]    tap_mask [0:DEPTH-1];

  assign gated_en = enable_i & dfi_wrdata_en_i;
  assign is_idle  = (state_q == ST_IDLE);

  // Latency and burst size track the inputs while idle so the first word of a
  // burst already sees the new settings.
  assign lat_eff  = is_idle ? wrlat_i : lat_q;
  assign n_eff    = is_idle ? n_cfg   : n_q;

  always_comb begin
    case (burstlength_i)
      2'b01:   n_cfg = 5'd4;
      2'b10:   n_cfg = 5'd16;
      default: n_cfg = 5'd8;
    endcase
  end

  // Tap 0 is the live gated input; taps 1..15 are the stored delay entries.
  always_comb begin
    tap_vld     = '0;
    tap_vld[0]  = gated_en;
    tap_data[0] = dfi_wrdata_i;
    tap_mask[0] = dfi_wrdata_mask_i;
    for (int k = 1; k < DEPTH; k++) begin
      tap_vld[k]  = vld_q[k];
      tap_data[k] = data_q[k];
      tap_mask[k] = mask_q[k];
    end
  end

  // Entries shifted past the active tap have already been emitted, so their
  // valid bit is dropped; this keeps a later latency change from replaying them.
  always_comb begin
    vld_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = tap_vld[k-1] && (4'(k) <= lat_eff);
      data_d[k] = tap_data[k-1];
      mask_d[k] = tap_mask[k-1];
    end
  end

  always_comb begin
    wr_en_d   = tap_vld[lat_eff];
    wr_data_d = '0;
    wr_mask_d = '0;
    if (wr_en_d) begin
      wr_data_d = tap_data[lat_eff];
      wr_mask_d = tap_mask[lat_eff];
    end
  end

  always_comb begin
    beat_d = 5'd0;
    if (gated_en && (beat_q != n_eff - 5'd1)) begin
      beat_d = beat_q + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gated_en) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!gated_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (gated_en)        state_d = ST_ACTIVE;
        else if (vld_q == '0) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lat_d     = is_idle ? wrlat_i : lat_q;
    n_d       = n_eff;
    lat_cond  = !is_idle && (wrlat_i != lat_q);
    lat_mis_d = lat_cond;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      lat_q     <= 4'd0;
      n_q       <= 5'd8;
      beat_q    <= 5'd0;
      lat_mis_q <= 1'b0;
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      n_q       <= n_d;
      beat_q    <= beat_d;
      lat_mis_q <= lat_mis_d;
      vld_q     <= vld_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    mask_q <= mask_d;
  end

  assign wr_en_o       = wr_en_q;
  assign wr_data_o     = wr_data_q;
  assign wr_datamask_o = wr_mask_q;
  assign busy_o        = !is_idle;
  // A nonzero beat count implies the previous cycle was enabled, so this is
  // exactly a falling edge inside a burst.
  assign burst_err_o   = !rst_i && !gated_en && (beat_q != 5'd0);
  assign lat_err_o     = !rst_i && lat_cond && !lat_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr5_phy_wrdata_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr5_phy_wrdata_align
//  Purpose  : Directed and randomized checks of ddr5_phy_wrdata_align against
//             a cycle-indexed word-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr5_phy_wrdata_align;

  localparam int P  = 4;
  localparam int DW = 2*P;
  localparam int MW = P/4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          dfi_en;
  logic [DW-1:0] dfi_data;
  logic [MW-1:0] dfi_mask;
  logic [3:0]    wrlat;
  logic [1:0]    bl;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          busy;
  logic          burst_err;
  logic          lat_err;

  ddr5_phy_wrdata_align #(.pDRAM_SIZE(P)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .dfi_wrdata_en_i   (dfi_en),
    .dfi_wrdata_i      (dfi_data),
    .dfi_wrdata_mask_i (dfi_mask),
    .wrlat_i           (wrlat),
    .burstlength_i     (bl),
    .wr_en_o           (wr_en),
    .wr_data_o         (wr_data),
    .wr_datamask_o     (wr_mask),
    .busy_o            (busy),
    .burst_err_o       (burst_err),
    .lat_err_o         (lat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } word_t;

  word_t q[$];
  int    cyc;
  int    checks;
  int    errors;
  logic  m_busy;
  int    m_lat;
  int    m_n;
  int    m_run;
  logic  m_prev_g;
  logic  m_mis;

  int    base;
  int    out_cnt, be_cnt, le_cnt;
  int    first_en, last_en, be_cyc, idle_at;
  logic  seen_busy;

  function automatic int bl_cycles(input logic [1:0] b);
    case (b)
      2'b01:   return 4;
      2'b10:   return 16;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic begin_scn();
    base      = cyc;
    out_cnt   = 0;
    be_cnt    = 0;
    le_cnt    = 0;
    first_en  = -1;
    last_en   = -1;
    be_cyc    = -1;
    idle_at   = -1;
    seen_busy = 1'b0;
  endtask

  // One clock cycle: compare DUT outputs against the model, then advance it.
  task automatic step();
    logic          g, cond, exp_en, exp_be, exp_le, pending;
    logic [DW-1:0] exp_d;
    logic [MW-1:0] exp_m;
    int            lat_eff, n_eff;
    word_t         w;
    @(negedge clk);
    g       = enable & dfi_en;
    lat_eff = m_busy ? m_lat : int'(wrlat);
    n_eff   = m_busy ? m_n : bl_cycles(bl);
    exp_en  = 1'b0;
    exp_d   = '0;
    exp_m   = '0;
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_en = 1'b1;
      exp_d  = q[0].d;
      exp_m  = q[0].m;
      void'(q.pop_front());
    end
    exp_be = !rst && !g && ((m_run % n_eff) != 0);
    cond   = m_busy && (int'(wrlat) != m_lat);
    exp_le = !rst && cond && !m_mis;

    chk("wr_en", 64'(wr_en), 64'(exp_en));
    chk("wr_data", 64'(wr_data), 64'(exp_d));
    chk("wr_mask", 64'(wr_mask), 64'(exp_m));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("burst_err", 64'(burst_err), 64'(exp_be));
    chk("lat_err", 64'(lat_err), 64'(exp_le));

    if (wr_en === 1'b1) begin
      out_cnt++;
      if (first_en < 0) first_en = cyc - base;
      last_en = cyc - base;
    end
    if (burst_err === 1'b1) begin
      be_cnt++;
      be_cyc = cyc - base;
    end
    if (lat_err === 1'b1) le_cnt++;
    if (busy === 1'b1) seen_busy = 1'b1;
    else if (seen_busy && idle_at < 0) idle_at = cyc - base;

    if (rst) begin
      q.delete();
      m_busy   = 1'b0;
      m_lat    = 0;
      m_n      = 8;
      m_run    = 0;
      m_mis    = 1'b0;
      m_prev_g = 1'b0;
    end else begin
      pending = 1'b0;
      foreach (q[i]) if (q[i].due > cyc) pending = 1'b1;
      if (g) begin
        w.due = cyc + lat_eff + 1;
        w.d   = dfi_data;
        w.m   = dfi_mask;
        q.push_back(w);
      end
      if (!m_busy) begin
        m_lat = int'(wrlat);
        m_n   = n_eff;
      end
      m_busy   = g || (m_busy && (m_prev_g || pending));
      m_mis    = cond;
      m_run    = g ? m_run + 1 : 0;
      m_prev_g = g;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic words(input int n);
    for (int i = 0; i < n; i++) begin
      dfi_en   = 1'b1;
      dfi_data = DW'($urandom);
      dfi_mask = MW'($urandom);
      step();
    end
    dfi_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst      = 1'b1;
    enable   = 1'b1;
    dfi_en   = 1'b0;
    dfi_data = '0;
    dfi_mask = '0;
    wrlat    = 4'd3;
    bl       = 2'b00;
    m_busy   = 1'b0;
    m_lat    = 0;
    m_n      = 8;
    m_run    = 0;
    m_prev_g = 1'b0;
    m_mis    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency 3, BL16: words at 10..17, outputs at 14..21, idle from 22.
    begin_scn();
    run(10);
    words(8);
    run(8);
    chk("s1_first", 64'(first_en), 64'(14));
    chk("s1_last", 64'(last_en), 64'(21));
    chk("s1_count", 64'(out_cnt), 64'(8));
    chk("s1_idle_at", 64'(idle_at), 64'(22));

    // Latency 0, BL8: two back-to-back bursts.
    wrlat = 4'd0;
    bl    = 2'b01;
    run(3);
    begin_scn();
    words(8);
    run(6);
    chk("s2_first", 64'(first_en), 64'(1));
    chk("s2_span", 64'(last_en - first_en), 64'(7));
    chk("s2_count", 64'(out_cnt), 64'(8));
    chk("s2_berr", 64'(be_cnt), 64'(0));

    // BL16 truncated after 5 words.
    wrlat = 4'd2;
    bl    = 2'b00;
    run(3);
    begin_scn();
    words(5);
    run(8);
    chk("s3_berr_cnt", 64'(be_cnt), 64'(1));
    chk("s3_berr_cyc", 64'(be_cyc), 64'(5));
    chk("s3_count", 64'(out_cnt), 64'(5));

    // Latency change while active.
    wrlat = 4'd3;
    run(3);
    begin_scn();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) wrlat = 4'd7;
      dfi_en   = 1'b1;
      dfi_data = DW'($urandom);
      dfi_mask = MW'($urandom);
      step();
    end
    dfi_en = 1'b0;
    run(10);
    chk("s4_laterr", 64'(le_cnt), 64'(1));
    chk("s4_first", 64'(first_en), 64'(4));
    chk("s4_last", 64'(last_en), 64'(11));

    // New latency picked up once idle.
    run(3);
    begin_scn();
    words(8);
    run(14);
    chk("s5_first", 64'(first_en), 64'(8));
    chk("s5_count", 64'(out_cnt), 64'(8));
    chk("s5_laterr", 64'(le_cnt), 64'(0));

    // Reset mid-burst at latency 5.
    wrlat = 4'd5;
    run(3);
    words(3);
    rst      = 1'b1;
    dfi_en   = 1'b1;
    dfi_data = DW'($urandom);
    step();
    rst    = 1'b0;
    dfi_en = 1'b0;
    begin_scn();
    run(20);
    chk("s6_stale", 64'(out_cnt), 64'(0));
    chk("s6_busy", 64'(seen_busy), 64'(0));
    chk("s6_errs", 64'(be_cnt + le_cnt), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      dfi_en   = ($urandom_range(0, 9) < 7);
      dfi_data = DW'($urandom);
      dfi_mask = MW'($urandom);
      if ($urandom_range(0, 29) == 0) wrlat = 4'($urandom);
      if ($urandom_range(0, 29) == 0) bl = 2'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst    = 1'b0;
    enable = 1'b1;
    dfi_en = 1'b0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
